inst_issuer: RTL and testbench
==============================

Name: inst_issuer

Overview:
Upstream sequencer for the systolic array core. It buffers packed instructions from a host-side program port and drives them, one at a time, onto the core's `instruction` input. Flag-handshaked AXI-transfer opcodes complete on the core's `flag`; all other opcodes complete after fixed cycle counts from the shared package. It replaces the hand-timed instruction driving currently done in the top-level bench.

Parameters:
- FIFO_DEPTH, 16, instruction queue entries (power of 2, ≥2).
- TIMEOUT_CYCLES, 4096, maximum cycles spent in each flag-wait phase before abort.
- CNT_BITS, 16, width of the fixed-cycle down-counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_inst  in  INST_BITS(20)  packed instruction: [19:16] opcode, [15:8] ADDRA, [7:0] ADDRB.
- in_valid  in  1  host presents in_inst.
- in_ready  out  1  queue accepts; equals !full.
- halt  in  1  inhibits new pops; the in-flight instruction still completes.
- clear_err  in  1  clears sticky errors.
- flag  in  1  core completion flag.
- instruction  out  20  instruction to the core.
- busy  out  1  an instruction is in flight.
- retire  out  1  one-cycle pulse in an instruction's final cycle.
- retire_opcode  out  4  opcode of the retiring instruction; valid with retire.
- err_timeout  out  1  sticky; set on flag-wait timeout.
- err_illegal  out  1  sticky; set on undefined opcode.
- q_count  out  $clog2(FIFO_DEPTH)+1  queue occupancy.

Behaviour:
- Reset: all outputs 0; `instruction` = IDLE (all zero); queue flushed; FSM to S_IDLE. Reset mid-instruction aborts it with no retire pulse.
- Queue:
  - Push when in_valid && in_ready.
  - in_ready = (q_count != FIFO_DEPTH), combinational from the count. When full, a same-cycle pop does not make room that cycle.
  - Simultaneous push and pop on a non-full queue leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Pop rule: pop when the queue is non-empty, halt=0, and either FSM is in S_IDLE or retire is asserted this cycle.
  - The popped word appears on `instruction` at the next edge.
  - Back-to-back instructions have zero bubble.
  - Minimum latency: push at edge k → on `instruction` after edge k+1.
- FSM states: S_IDLE, S_WAIT_LOW, S_WAIT_HIGH, S_COUNT, S_ILLEGAL. The state is chosen from the popped opcode.
- AXI class (AXI_TO_UB=1, AXI_TO_WB=2, UB_TO_AXI=8):
  - S_WAIT_LOW until flag==0.
  - Then S_WAIT_HIGH until flag==1; retire in the cycle flag==1 is sampled in S_WAIT_HIGH.
  - Each wait phase has its own timeout counter. Reaching TIMEOUT_CYCLES sets err_timeout, drives IDLE and returns to S_IDLE with no retire.
- Fixed class:
  - Opcodes: IDLE=0, UB_TO_DATA_FIFO=3, UB_TO_WEIGHT_FIFO=4, MAT_MUL=5, MAT_MUL_ACC=6, ACC_TO_UB=7, READ_UB=9.
  - Held on `instruction` for exactly N cycles, N = package constant (IDLE 1, DFIFO 2, WFIFO 2, MAT_MUL 8, MAT_MUL_ACC 8, ACC_TO_UB 2, READ_UB 2).
  - Retire in cycle N. N=0 is treated as 1.
- Illegal opcodes (10–15):
  - One cycle in S_ILLEGAL; `instruction` forced to IDLE.
  - err_illegal set; retire pulses with the illegal opcode.
- Idle output: when nothing is in flight, `instruction` = IDLE (opcode 0, addresses 0).
- busy = 1 in any state other than S_IDLE.
- Sticky errors: hold until clear_err. If clear_err and a new error coincide, set wins.
- halt asserted mid-instruction: no effect until retire.

Optional Feature:
- INST_ISSUER_PERF_EN defined:
  - Adds outputs perf_retired (32 bits, counts retire pulses) and perf_busy (32 bits, counts busy cycles).
  - Both counters wrap, and both clear on reset or clear_err.
- Undefined: these ports and counters are absent.

Decomposition:
- Shared package (tpu_inst_pkg): opcode localparams, field FROM/TO bit positions, INST_BITS, per-opcode *_CYCLE constants, an opcode-class function (AXI / FIXED / ILLEGAL).
- One sub-module: inst_fifo (parameterised synchronous FIFO with count). The FSM and counters live in the top.

Test Plan:
- Push MAT_MUL (0x5_03_04) into an empty queue → `instruction`=0x50304 for exactly 8 cycles starting 2 cycles after push; retire with opcode 5 in cycle 8; then IDLE.
- Push AXI_TO_UB (0x1_02_08); bench holds flag=1 for 3 cycles, low for 5, then high → instruction held throughout; retire the cycle flag rises; err flags 0.
- Push 17 entries with FIFO_DEPTH=16 while halt=1 → in_ready drops after the 16th push; q_count=16; release halt → 16 instructions issue back-to-back with no IDLE gap.
- AXI_TO_WB with flag stuck 1 and TIMEOUT_CYCLES=32 → err_timeout after 32 wait cycles, instruction=IDLE, no retire; next queued instruction issues; clear_err clears the error.
- Push opcode 0xC → err_illegal set, retire_opcode=0xC, instruction stays IDLE; a following READ_UB issues normally for 2 cycles.
- Assert reset during cycle 4 of MAT_MUL with 3 entries queued → next cycle: instruction=0, q_count=0, busy=0, no retire.

Source files
------------

// File: rtl/tpu_inst_pkg.sv
// ---------------------------------------------------------------------------
// tpu_inst_pkg
// Shared instruction definitions for the systolic array core and its
// sequencer: opcode values, field bit positions, per-opcode hold times and
// an opcode classifier.
//   INST_BITS   : packed instruction width ([19:16] op, [15:8] A, [7:0] B)
//   *_CYCLE     : cycles a fixed-class opcode is held on the core input
//   op_class()  : AXI (flag handshaked) / FIXED (timed) / ILLEGAL
//   fixed_cycles(): hold time of a fixed-class opcode, never below 1
// ---------------------------------------------------------------------------
package tpu_inst_pkg;

  localparam int INST_BITS  = 20;
  localparam int OP_BITS    = 4;
  localparam int OP_FROM    = 19;
  localparam int OP_TO      = 16;
  localparam int ADDRA_FROM = 15;
  localparam int ADDRA_TO   = 8;
  localparam int ADDRB_FROM = 7;
  localparam int ADDRB_TO   = 0;

  localparam logic [3:0] OP_IDLE              = 4'd0;
  localparam logic [3:0] OP_AXI_TO_UB         = 4'd1;
  localparam logic [3:0] OP_AXI_TO_WB         = 4'd2;
  localparam logic [3:0] OP_UB_TO_DATA_FIFO   = 4'd3;
  localparam logic [3:0] OP_UB_TO_WEIGHT_FIFO = 4'd4;
  localparam logic [3:0] OP_MAT_MUL           = 4'd5;
  localparam logic [3:0] OP_MAT_MUL_ACC       = 4'd6;
  localparam logic [3:0] OP_ACC_TO_UB         = 4'd7;
  localparam logic [3:0] OP_UB_TO_AXI         = 4'd8;
  localparam logic [3:0] OP_READ_UB           = 4'd9;

  localparam int IDLE_CYCLE              = 1;
  localparam int UB_TO_DATA_FIFO_CYCLE   = 2;
  localparam int UB_TO_WEIGHT_FIFO_CYCLE = 2;
  localparam int MAT_MUL_CYCLE           = 8;
  localparam int MAT_MUL_ACC_CYCLE       = 8;
  localparam int ACC_TO_UB_CYCLE         = 2;
  localparam int READ_UB_CYCLE           = 2;

  localparam logic [INST_BITS-1:0] IDLE_WORD = 20'h00000;

  typedef enum logic [1:0] {
    CLS_AXI     = 2'd0,
    CLS_FIXED   = 2'd1,
    CLS_ILLEGAL = 2'd2
  } op_class_e;

  function automatic op_class_e op_class(input logic [3:0] op);
    op_class_e cls;
    case (op)
      OP_AXI_TO_UB, OP_AXI_TO_WB, OP_UB_TO_AXI: cls = CLS_AXI;
      OP_IDLE, OP_UB_TO_DATA_FIFO, OP_UB_TO_WEIGHT_FIFO, OP_MAT_MUL,
      OP_MAT_MUL_ACC, OP_ACC_TO_UB, OP_READ_UB:  cls = CLS_FIXED;
      default:                                   cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

  // A zero hold time would never retire, so it is clamped to one cycle.
  function automatic logic [31:0] fixed_cycles(input logic [3:0] op);
    logic [31:0] n;
    case (op)
      OP_IDLE:              n = 32'(IDLE_CYCLE);
      OP_UB_TO_DATA_FIFO:   n = 32'(UB_TO_DATA_FIFO_CYCLE);
      OP_UB_TO_WEIGHT_FIFO: n = 32'(UB_TO_WEIGHT_FIFO_CYCLE);
      OP_MAT_MUL:           n = 32'(MAT_MUL_CYCLE);
      OP_MAT_MUL_ACC:       n = 32'(MAT_MUL_ACC_CYCLE);
      OP_ACC_TO_UB:         n = 32'(ACC_TO_UB_CYCLE);
      OP_READ_UB:           n = 32'(READ_UB_CYCLE);
      default:              n = 32'd1;
    endcase
    if (n == 32'd0) begin
      n = 32'd1;
    end else begin
      n = n;
    end
    return n;
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// ---------------------------------------------------------------------------
// inst_fifo
// Synchronous FIFO with occupancy count. Push is ignored when full and pop
// is ignored when empty, so a pop while full does not free a slot in the
// same cycle. Read data is the head entry, valid whenever !empty_o.
//   clk, reset : clock, synchronous active-high reset (flushes the queue)
//   push_i/wdata_i : enqueue request and data
//   pop_i      : dequeue request
//   rdata_o    : head entry
//   full_o, empty_o, count_o : status
// ---------------------------------------------------------------------------
module inst_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q;
  logic [PTR_W-1:0] rptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_o    = (cnt_q == CNT_W'(DEPTH));
  assign empty_o   = (cnt_q == {CNT_W{1'b0}});
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;
  assign rdata_o   = mem_q[rptr_q];
  assign count_o   = cnt_q;

  // Pointer and count update; DEPTH is a power of two so pointers wrap freely.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= {PTR_W{1'b0}};
      rptr_q <= {PTR_W{1'b0}};
      cnt_q  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) wptr_q <= wptr_q + PTR_W'(1);
      if (do_pop_s)  rptr_q <= rptr_q + PTR_W'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage array; contents need no reset since the count guards reads.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/inst_issuer.sv
// ---------------------------------------------------------------------------
// inst_issuer
// Buffers host instructions and issues them one at a time to the systolic
// core. AXI transfer opcodes complete on a low-then-high handshake of `flag`
// (each phase guarded by a timeout); other legal opcodes are held for a fixed
// cycle count; illegal opcodes spend one cycle and raise a sticky error.
//   clk, reset     : clock, synchronous active-high reset
//   in_inst/in_valid/in_ready : host program port (in_ready = !full)
//   halt           : blocks new issues, in-flight instruction completes
//   clear_err      : clears sticky errors (a coincident new error wins)
//   flag           : core completion flag
//   instruction    : word driven to the core (IDLE when nothing in flight)
//   busy           : instruction in flight
//   retire/retire_opcode : pulse in an instruction's final cycle
//   err_timeout/err_illegal : sticky error flags
//   q_count        : queue occupancy
// Optional: define INST_ISSUER_PERF_EN to add perf_retired / perf_busy
// wrapping counters, cleared by reset or clear_err.
// ---------------------------------------------------------------------------
module inst_issuer
  import tpu_inst_pkg::*;
#(
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_BITS       = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [INST_BITS-1:0]        in_inst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        halt,
  input  logic                        clear_err,
  input  logic                        flag,
  output logic [INST_BITS-1:0]        instruction,
  output logic                        busy,
  output logic                        retire,
  output logic [OP_BITS-1:0]          retire_opcode,
  output logic                        err_timeout,
  output logic                        err_illegal,
  output logic [$clog2(FIFO_DEPTH):0] q_count
`ifdef INST_ISSUER_PERF_EN
  ,
  output logic [31:0]                 perf_retired,
  output logic [31:0]                 perf_busy
`endif
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_LOW  = 3'd1;
  localparam logic [2:0] S_WAIT_HIGH = 3'd2;
  localparam logic [2:0] S_COUNT     = 3'd3;
  localparam logic [2:0] S_ILLEGAL   = 3'd4;

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]           state_q, state_d;
  logic [INST_BITS-1:0] inst_q, inst_d;
  logic [OP_BITS-1:0]   op_q, op_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic                 err_to_q, err_il_q;
  logic                 to_set_s, il_set_s;
  logic                 retire_s, pop_s;
  logic [INST_BITS-1:0] fifo_rdata_s;
  logic                 fifo_full_s, fifo_empty_s;
  logic [OP_BITS-1:0]   pop_op_s;
  op_class_e            pop_cls_s;

  inst_fifo #(
    .WIDTH (INST_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (in_valid),
    .wdata_i (in_inst),
    .pop_i   (pop_s),
    .rdata_o (fifo_rdata_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (q_count)
  );

  assign in_ready  = !fifo_full_s;
  assign pop_op_s  = fifo_rdata_s[OP_FROM:OP_TO];
  assign pop_cls_s = op_class(pop_op_s);

  // Final-cycle detection; an AXI op retires in the same cycle flag reads 1.
  // Gated by reset so an aborted instruction never pulses retire.
  always_comb begin
    retire_s = 1'b0;
    if (!reset) begin
      case (state_q)
        S_COUNT:     retire_s = (cnt_q == {CNT_BITS{1'b0}});
        S_WAIT_HIGH: retire_s = flag;
        S_ILLEGAL:   retire_s = 1'b1;
        default:     retire_s = 1'b0;
      endcase
    end else begin
      retire_s = 1'b0;
    end
  end

  // Issuing in the retire cycle gives back-to-back instructions with no bubble.
  assign pop_s = !fifo_empty_s && !halt && !reset &&
                 ((state_q == S_IDLE) || retire_s);

  // Sequencer next state: load a popped word, finish, or advance the phase.
  always_comb begin
    state_d  = state_q;
    inst_d   = inst_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    to_set_s = 1'b0;
    il_set_s = 1'b0;
    if (pop_s) begin
      op_d  = pop_op_s;
      tmo_d = {TMO_W{1'b0}};
      cnt_d = {CNT_BITS{1'b0}};
      case (pop_cls_s)
        CLS_AXI: begin
          state_d = S_WAIT_LOW;
          inst_d  = fifo_rdata_s;
        end
        CLS_FIXED: begin
          state_d = S_COUNT;
          inst_d  = fifo_rdata_s;
          cnt_d   = CNT_BITS'(fixed_cycles(pop_op_s) - 32'd1);
        end
        default: begin
          state_d  = S_ILLEGAL;
          inst_d   = IDLE_WORD;
          il_set_s = 1'b1;
        end
      endcase
    end else if (retire_s) begin
      state_d = S_IDLE;
      inst_d  = IDLE_WORD;
    end else begin
      case (state_q)
        S_WAIT_LOW: begin
          if (!flag) begin
            state_d = S_WAIT_HIGH;
            tmo_d   = {TMO_W{1'b0}};
          end else if (tmo_q == TMO_LAST) begin
            to_set_s = 1'b1;
            state_d  = S_IDLE;
            inst_d   = IDLE_WORD;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
        S_WAIT_HIGH: begin
          // flag==1 here is the retire path above; only flag==0 reaches this.
          if (tmo_q == TMO_LAST) begin
            to_set_s = 1'b1;
            state_d  = S_IDLE;
            inst_d   = IDLE_WORD;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
        S_COUNT: begin
          cnt_d = cnt_q - CNT_BITS'(1);
        end
        S_IDLE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          inst_d  = IDLE_WORD;
        end
      endcase
    end
  end

  // Sequencer registers and sticky errors (set has priority over clear).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      inst_q   <= IDLE_WORD;
      op_q     <= 4'd0;
      cnt_q    <= {CNT_BITS{1'b0}};
      tmo_q    <= {TMO_W{1'b0}};
      err_to_q <= 1'b0;
      err_il_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      inst_q   <= inst_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      err_to_q <= (err_to_q & ~clear_err) | to_set_s;
      err_il_q <= (err_il_q & ~clear_err) | il_set_s;
    end
  end

  assign instruction   = inst_q;
  assign busy          = (state_q != S_IDLE);
  assign retire        = retire_s;
  assign retire_opcode = retire_s ? op_q : 4'd0;
  assign err_timeout   = err_to_q;
  assign err_illegal   = err_il_q;

`ifdef INST_ISSUER_PERF_EN
  logic [31:0] perf_ret_q;
  logic [31:0] perf_busy_q;

  // Free-running wrapping activity counters.
  always_ff @(posedge clk) begin
    if (reset || clear_err) begin
      perf_ret_q  <= 32'd0;
      perf_busy_q <= 32'd0;
    end else begin
      perf_ret_q  <= perf_ret_q + (retire_s ? 32'd1 : 32'd0);
      perf_busy_q <= perf_busy_q + (busy ? 32'd1 : 32'd0);
    end
  end

  assign perf_retired = perf_ret_q;
  assign perf_busy    = perf_busy_q;
`endif

endmodule

// File: tb/tb_inst_issuer.sv
// ---------------------------------------------------------------------------
// tb_inst_issuer
// Directed bench for inst_issuer (FIFO_DEPTH=16, TIMEOUT_CYCLES=32). A
// transaction-level model (queue of words plus the in-flight instruction's
// remaining time) predicts every output each cycle; literal expectations pin
// the scenario results.
// ---------------------------------------------------------------------------
module tb_inst_issuer;

  localparam int DEPTH = 16;
  localparam int TMO   = 32;
  localparam int PH_FIX = 0, PH_LOW = 1, PH_HIGH = 2, PH_ILL = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] in_inst = 20'h0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        halt = 1'b0;
  logic        clear_err = 1'b0;
  logic        flag = 1'b0;
  logic [19:0] instruction;
  logic        busy;
  logic        retire;
  logic [3:0]  retire_opcode;
  logic        err_timeout;
  logic        err_illegal;
  logic [4:0]  q_count;

  inst_issuer #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO),
    .CNT_BITS       (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_inst       (in_inst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .halt          (halt),
    .clear_err     (clear_err),
    .flag          (flag),
    .instruction   (instruction),
    .busy          (busy),
    .retire        (retire),
    .retire_opcode (retire_opcode),
    .err_timeout   (err_timeout),
    .err_illegal   (err_illegal),
    .q_count       (q_count)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // model state
  logic [19:0] mq[$];
  logic        m_act = 1'b0;
  logic [19:0] m_word = 20'h0;
  int          m_ph = PH_FIX;
  int          m_left = 0;
  int          m_wait = 0;
  logic        m_eto = 1'b0;
  logic        m_eil = 1'b0;
  logic        model_ok = 1'b0;

  // observations
  int          cyc = 0;
  logic [19:0] watch = 20'h0;
  int          n_watch, first_watch, n_ret, n_nz, first_nz, last_nz, ret_cyc;
  logic [3:0]  ret_ops[$];
  logic [19:0] o_inst;
  logic        o_busy, o_ret, o_eto, o_eil, o_rdy;
  logic [4:0]  o_qc;

  function automatic int hold_cycles(input logic [3:0] op);
    case (op)
      4'd0:    return 1;
      4'd5:    return 8;
      4'd6:    return 8;
      default: return 2;
    endcase
  endfunction

  function automatic logic m_retire();
    return !reset && m_act &&
           ((m_ph == PH_FIX && m_left == 1) || m_ph == PH_ILL ||
            (m_ph == PH_HIGH && flag));
  endfunction

  function automatic logic [33:0] model_out();
    logic [19:0] ei;
    logic        er;
    ei = (m_act && m_ph != PH_ILL) ? m_word : 20'h0;
    er = m_retire();
    return {ei, m_act, er, (er ? m_word[19:16] : 4'h0), m_eto, m_eil,
            5'(mq.size()), (mq.size() != DEPTH)};
  endfunction

  task automatic model_step();
    logic        ret;
    logic        was_act;
    int          sz;
    logic [19:0] w;
    logic [3:0]  op;
    if (reset) begin
      mq.delete();
      m_act = 1'b0; m_eto = 1'b0; m_eil = 1'b0; m_word = 20'h0;
      model_ok = 1'b1;
      return;
    end
    ret = m_retire();
    was_act = m_act;
    sz = mq.size();
    if (clear_err) begin
      m_eto = 1'b0;
      m_eil = 1'b0;
    end
    if (m_act) begin
      if (ret) m_act = 1'b0;
      else if (m_ph == PH_FIX) m_left--;
      else if (m_ph == PH_LOW && !flag) begin
        m_ph = PH_HIGH;
        m_wait = 0;
      end else if (m_ph == PH_LOW || m_ph == PH_HIGH) begin
        m_wait++;
        if (m_wait == TMO) begin
          m_act = 1'b0;
          m_eto = 1'b1;
        end
      end
    end
    if (sz > 0 && !halt && (!was_act || ret)) begin
      w = mq.pop_front();
      op = w[19:16];
      m_act = 1'b1;
      m_word = w;
      if (op == 4'd1 || op == 4'd2 || op == 4'd8) begin
        m_ph = PH_LOW;
        m_wait = 0;
      end else if (op <= 4'd9) begin
        m_ph = PH_FIX;
        m_left = hold_cycles(op);
      end else begin
        m_ph = PH_ILL;
        m_eil = 1'b1;
      end
    end
    if (in_valid && sz != DEPTH) mq.push_back(in_inst);
  endtask

  task automatic clear_obs(input logic [19:0] w);
    watch = w; n_watch = 0; first_watch = -1; n_ret = 0; n_nz = 0;
    first_nz = -1; last_nz = -1; ret_cyc = -1; ret_ops.delete();
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d expected=%0d", name, got, exp);
  endtask

  // One clock: compare at the negedge, then advance the model at the posedge.
  task automatic cycle();
    logic [33:0] g;
    logic [33:0] e;
    @(negedge clk);
    cyc++;
    g = {instruction, busy, retire, retire_opcode, err_timeout, err_illegal,
         q_count, in_ready};
    e = model_out();
    if (model_ok) begin
      n_total++;
      if (g === e) n_pass++;
      else $display("FAIL cycle%0d outputs got=%h expected=%h", cyc, g, e);
    end
    o_inst = instruction; o_busy = busy; o_ret = retire; o_eto = err_timeout;
    o_eil = err_illegal; o_qc = q_count; o_rdy = in_ready;
    if (instruction == watch) begin
      n_watch++;
      if (first_watch < 0) first_watch = cyc;
    end
    if (instruction != 20'h0) begin
      n_nz++;
      if (first_nz < 0) first_nz = cyc;
      last_nz = cyc;
    end
    if (retire) begin
      n_ret++;
      ret_cyc = cyc;
      ret_ops.push_back(retire_opcode);
    end
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic push(input logic [19:0] w);
    in_inst = w;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
  endtask

  int p, rise;
  logic rdy_15, rdy_16;

  initial begin
    // reset
    reset = 1'b1;
    cycle(); cycle();
    reset = 1'b0;
    cycle();
    check("rst_inst", int'(o_inst), 0);
    check("rst_busy", int'(o_busy), 0);
    check("rst_qcount", int'(o_qc), 0);
    check("rst_ready", int'(o_rdy), 1);

    // MAT_MUL into an empty queue
    clear_obs(20'h50304);
    p = cyc + 1;
    push(20'h50304);
    repeat (12) cycle();
    check("mm_hold", n_watch, 8);
    check("mm_start", first_watch - p, 2);
    check("mm_retires", n_ret, 1);
    check("mm_ret_op", (n_ret > 0) ? int'(ret_ops[0]) : -1, 5);
    check("mm_ret_last", ret_cyc, first_watch + 7);
    check("mm_idle_after", int'(o_inst), 0);

    // AXI_TO_UB handshake: flag 1 x3, 0 x5, then 1
    clear_obs(20'h10208);
    flag = 1'b1;
    push(20'h10208);
    cycle();
    repeat (3) cycle();
    flag = 1'b0;
    repeat (5) cycle();
    flag = 1'b1;
    rise = cyc + 1;
    cycle();
    flag = 1'b0;
    repeat (3) cycle();
    check("axi_hold", n_watch, 9);
    check("axi_retires", n_ret, 1);
    check("axi_ret_cycle", ret_cyc, rise);
    check("axi_ret_op", (n_ret > 0) ? int'(ret_ops[0]) : -1, 1);
    check("axi_errs", int'({o_eto, o_eil}), 0);

    // fill under halt, then drain back-to-back
    halt = 1'b1;
    rdy_15 = 1'b0;
    rdy_16 = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_inst = {4'h4, 8'(i + 1), 8'(i)};
      in_valid = 1'b1;
      cycle();
      if (i == 15) rdy_15 = o_rdy;
      if (i == 16) rdy_16 = o_rdy;
    end
    in_valid = 1'b0;
    cycle();
    check("fill_ready_16th", int'(rdy_15), 1);
    check("fill_ready_17th", int'(rdy_16), 0);
    check("fill_qcount", int'(o_qc), 16);
    clear_obs(20'hFFFFF);
    halt = 1'b0;
    repeat (40) cycle();
    check("drain_retires", n_ret, 16);
    check("drain_busy_cycles", n_nz, 32);
    check("drain_no_gap", last_nz - first_nz + 1, 32);
    check("drain_qcount", int'(o_qc), 0);

    // AXI_TO_WB timeout, then queued READ_UB
    flag = 1'b1;
    clear_obs(20'h21122);
    push(20'h21122);
    push(20'h93344);
    repeat (42) cycle();
    check("tmo_hold", n_watch, TMO);
    check("tmo_err", int'(o_eto), 1);
    check("tmo_retires", n_ret, 1);
    check("tmo_next_op", (n_ret > 0) ? int'(ret_ops[0]) : -1, 9);
    clear_err = 1'b1;
    cycle();
    clear_err = 1'b0;
    cycle();
    check("tmo_cleared", int'(o_eto), 0);
    flag = 1'b0;

    // illegal opcode 0xC; clear_err coincides with the error being set
    clear_obs(20'h97788);
    push(20'hC5566);
    in_inst = 20'h97788;
    in_valid = 1'b1;
    clear_err = 1'b1;
    cycle();
    in_valid = 1'b0;
    clear_err = 1'b0;
    repeat (6) cycle();
    check("ill_err", int'(o_eil), 1);
    check("ill_retires", n_ret, 2);
    check("ill_ret_op", (n_ret > 0) ? int'(ret_ops[0]) : -1, 12);
    check("ill_inst_nz", n_nz, 2);
    check("ill_next_hold", n_watch, 2);
    clear_err = 1'b1;
    cycle();
    clear_err = 1'b0;
    cycle();
    check("ill_cleared", int'(o_eil), 0);

    // reset during cycle 4 of MAT_MUL with 3 entries queued
    push(20'h50304);
    push(20'h90101);
    push(20'h90202);
    push(20'h90303);
    cycle();
    reset = 1'b1;
    cycle();
    check("pre_rst_inst", int'(o_inst), 32'h50304);
    check("pre_rst_qcount", int'(o_qc), 3);
    reset = 1'b0;
    cycle();
    check("post_rst_inst", int'(o_inst), 0);
    check("post_rst_qcount", int'(o_qc), 0);
    check("post_rst_busy", int'(o_busy), 0);
    check("post_rst_retire", int'(o_ret), 0);
    repeat (4) cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
